// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - command encodings, FSM states and sizing helpers for the SPI master sequencer
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = DEF_DATA_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_RWSEL = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RECV  = 3'd5,
    ST_END   = 3'd6,
    ST_GAP   = 3'd7
  } state_e;

  function automatic int frame_width(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parallel-load MSB-first shift register with serial-in
module spi_shift_reg #(
  parameter int W     = 10,
  parameter int TAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [W-1:0]     load_data_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic             sout_o,
  output logic [TAP_W-1:0] tap_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[W-2:0], sin_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign sout_o = data_q[W-1];
  assign tap_o  = data_q[TAP_W-1:0];

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - single-clock SPI master framing one command per handshake onto SS_n/MOSI
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int IDLE_GAP = 1,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [DATA_W-1:0] req_payload,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int FW    = frame_width(DATA_W);
  localparam int CNT_W = $clog2(max_of(max_of(FW, DATA_W), max_of(RD_LAT, IDLE_GAP)));

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FW - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         cmd_q;
  logic               ss_n_q;
  logic               mosi_q;
  logic               ready_q;
  logic               busy_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;

  logic               accept;
  logic               sr_shift;
  logic               sr_sin;
  logic               sr_msb;
  logic [DATA_W-1:0]  sr_tap;

  assign accept   = (state_q == ST_IDLE) && req_valid && ready_q;
  // One register serves both directions: it drains the frame during SHIFT and fills from MISO during RECV.
  assign sr_shift = (state_q == ST_RWSEL) || (state_q == ST_RECV) ||
                    ((state_q == ST_SHIFT) && (cnt_q != '0));
  assign sr_sin   = (state_q == ST_RECV) && MISO;

  spi_shift_reg #(
    .W     (FW),
    .TAP_W (DATA_W)
  ) u_shift_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i ({req_cmd, req_payload}),
    .shift_i     (sr_shift),
    .sin_i       (sr_sin),
    .sout_o      (sr_msb),
    .tap_o       (sr_tap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= CMD_WR_ADDR;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q   <= req_cmd;
            state_q <= ST_SEL;
            ss_n_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SEL: begin
          state_q <= ST_RWSEL;
          mosi_q  <= cmd_q[1];
        end
        ST_RWSEL: begin
          state_q <= ST_SHIFT;
          mosi_q  <= sr_msb;
          cnt_q   <= SHIFT_LAST;
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            mosi_q <= sr_msb;
            cnt_q  <= cnt_q - 1'b1;
          end else begin
            mosi_q <= 1'b0;
            if (cmd_q == CMD_RD_DATA) begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LAST;
            end else begin
              state_q <= ST_END;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= ST_RECV;
            cnt_q   <= RECV_LAST;
          end
        end
        ST_RECV: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // The last MISO bit is folded in here so the byte and its pulse land together in END.
            state_q     <= ST_END;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= {sr_tap[DATA_W-2:0], MISO};
          end
        end
        ST_END: begin
          state_q <= ST_GAP;
          ss_n_q  <= 1'b1;
          cnt_q   <= GAP_LAST;
        end
        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl against a cycle-index frame model
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int IDLE_GAP = 1;
  localparam int DW       = 8;
  localparam int LEN_WR   = FRAME_W + 3;
  localparam int LEN_RD   = FRAME_W + 3 + RD_LAT + DW;
  localparam int RECV0    = FRAME_W + 2 + RD_LAT;
  localparam int IDLE_K   = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_cmd = 2'b00;
  logic [DW-1:0] req_payload = '0;
  logic          MISO = 1'b0;
  logic          req_ready, rsp_valid, busy, SS_n, MOSI;
  logic [DW-1:0] rsp_data;

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_LAT(RD_LAT), .IDLE_GAP(IDLE_GAP), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_payload(req_payload), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  // Reference model: k counts cycles since the accepting edge; the slave RAM is a plain array.
  int            k;
  int            m_len;
  int            n_acc = 0;
  logic [1:0]    m_cmd;
  logic [DW-1:0] m_pay;
  logic [DW-1:0] m_rsp;
  logic          m_fresh;
  bit   [7:0]    ram [256];
  bit   [7:0]    wr_addr, rd_addr, m_byte;
  logic          e_ss, e_mosi, e_busy, e_ready, e_rv;
  logic [FRAME_W-1:0] fr, fsh;

  assign m_len = (m_cmd == CMD_RD_DATA) ? LEN_RD : LEN_WR;

  always_comb begin
    fr = {m_cmd, m_pay};
    fsh = '0;
    e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_ready = 1'b0; e_rv = 1'b0;
    if (k < m_len) begin
      e_ss = 1'b0;
      e_busy = 1'b1;
      if (k == 1) begin
        e_mosi = m_cmd[1];
      end else if (k >= 2 && k <= FRAME_W + 1) begin
        fsh = fr << (k - 2);
        e_mosi = fsh[FRAME_W-1];
      end
      e_rv = (m_cmd == CMD_RD_DATA) && (k == m_len - 1);
    end else if (k < m_len + IDLE_GAP) begin
      e_busy = 1'b1;
    end else begin
      e_ready = !m_fresh;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= IDLE_K; m_cmd <= CMD_WR_ADDR; m_pay <= '0; m_fresh <= 1'b1; m_rsp <= '0;
    end else begin
      m_fresh <= 1'b0;
      if (e_ready && req_valid) begin
        k <= 0; m_cmd <= req_cmd; m_pay <= req_payload; n_acc <= n_acc + 1;
        if (req_cmd == CMD_RD_DATA) m_byte <= ram[rd_addr];
      end else begin
        if (k < IDLE_K) k <= k + 1;
        if (m_cmd == CMD_RD_DATA && k == m_len - 2) m_rsp <= m_byte;
        if (k == m_len - 1) begin
          case (m_cmd)
            CMD_WR_ADDR: wr_addr <= m_pay;
            CMD_WR_DATA: ram[wr_addr] <= m_pay;
            CMD_RD_ADDR: rd_addr <= m_pay;
            default: ;
          endcase
        end
      end
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  int sent = 0;
  int rv_cnt = 0;
  int frames = 0;
  int hi_run = 0;
  int min_hi = IDLE_K;
  logic [DW-1:0] rv_last = '0;
  logic prev_ss = 1'b1;
  logic [DW-1:0] bsh;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("cycle_outputs", 32'({SS_n, MOSI, busy, req_ready, rsp_valid, rsp_data}),
          32'({e_ss, e_mosi, e_busy, e_ready, e_rv, m_rsp}));
    if (rsp_valid) begin rv_cnt++; rv_last = rsp_data; end
    if (prev_ss && !SS_n) begin
      frames++;
      if (frames > 1 && hi_run < min_hi) min_hi = hi_run;
    end
    hi_run = SS_n ? hi_run + 1 : 0;
    prev_ss = SS_n;
    if (m_cmd == CMD_RD_DATA && k >= RECV0 && k < RECV0 + DW) begin
      bsh = m_byte << (k - RECV0);
      MISO = bsh[DW-1];
    end else begin
      MISO = 1'($urandom);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [DW-1:0] p);
    int n = 0;
    req_valid = 1'b1; req_cmd = c; req_payload = p;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check("handshake_timeout", 32'(req_ready), 32'd1);
    tick();
    sent++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check("idle_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic capture(input bit tog, output int len, output logic [31:0] bits);
    len = 0; bits = '0;
    while (SS_n == 1'b0 && len < 64) begin
      bits = {bits[30:0], MOSI};
      len++;
      if (tog) begin
        req_valid = ~req_valid; req_cmd = 2'($urandom); req_payload = DW'($urandom);
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic do_frame(input logic [1:0] c, input logic [DW-1:0] p, input bit tog,
                          input int exp_len, input logic [31:0] exp_bits, input string nm);
    int len;
    logic [31:0] bits;
    send(c, p);
    req_valid = 1'b0;
    capture(tog, len, bits);
    check({nm, "_len"}, len, exp_len);
    check({nm, "_mosi"}, bits, exp_bits);
    wait_idle();
    check({nm, "_ready_after_gap"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0;
    logic [1:0] c;
    logic [DW-1:0] p;

    tick();
    check("reset_outputs", 32'({SS_n, MOSI, busy, req_ready, rsp_valid, rsp_data}), 32'h1000);
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_release", 32'(req_ready), 32'd1);

    do_frame(CMD_WR_ADDR, 8'h04, 1'b0, 13, 32'h0008, "wr_addr");
    do_frame(CMD_WR_DATA, 8'h0F, 1'b0, 13, 32'h021E, "wr_data");
    do_frame(CMD_RD_ADDR, 8'h04, 1'b0, 13, 32'h0C08, "rd_addr");
    rv0 = rv_cnt;
    do_frame(CMD_RD_DATA, 8'h5A, 1'b0, 23, 32'h3AD000, "rd_data");
    check("rd_data_pulses", rv_cnt - rv0, 1);
    check("rd_data_value", 32'(rv_last), 32'h0F);

    rv0 = rv_cnt;
    do_frame(CMD_RD_DATA, 8'h00, 1'b1, 23, 32'h380000, "busy_toggle");
    check("busy_toggle_pulses", rv_cnt - rv0, 1);
    check("busy_toggle_value", 32'(rsp_data), 32'h0F);

    frames = 0; min_hi = IDLE_K; rv0 = rv_cnt;
    send(CMD_WR_ADDR, 8'h10);
    send(CMD_WR_DATA, 8'h77);
    send(CMD_RD_ADDR, 8'h10);
    send(CMD_RD_DATA, 8'h00);
    req_valid = 1'b0;
    tick();
    wait_idle();
    check("b2b_frames", frames, 4);
    check("b2b_min_gap_ok", 32'(min_hi >= IDLE_GAP), 32'd1);
    check("b2b_pulses", rv_cnt - rv0, 1);
    check("b2b_value", 32'(rv_last), 32'h77);

    send(CMD_WR_ADDR, 8'h3C);
    req_valid = 1'b0;
    repeat (6) tick();
    check("shift_bit5_mosi", 32'(MOSI), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ss", 32'(SS_n), 32'd1);
    check("async_rst_mosi", 32'(MOSI), 32'd0);
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_frame(CMD_WR_ADDR, 8'hA5, 1'b0, 13, 32'h014A, "post_reset");

    for (int i = 0; i < 60; i++) begin
      c = 2'($urandom);
      p = (c == CMD_WR_ADDR || c == CMD_RD_ADDR) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      send(c, p);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 20)) tick();
      end
    end
    req_valid = 1'b0;
    tick();
    wait_idle();
    repeat (3) tick();
    check("accepted_count", n_acc, sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
